// File: rtl/mnist_pkg.sv
// mnist_pkg: field layout, sizes and FSM states shared by the packer and the class trainers.
package mnist_pkg;
    localparam int N_PIX     = 784;
    localparam int N_CLASS   = 10;
    localparam int IMG_W     = N_PIX + N_CLASS;
    localparam int LABEL_LSB = 0;
    localparam int PIX_LSB   = N_CLASS;
    localparam int PIX_W     = 8;
    localparam int CNT_W     = 10;
    localparam logic [PIX_W-1:0] PIX_THRESH = 8'd128;
    localparam logic [PIX_W-1:0] LABEL_MAX  = PIX_W'(N_CLASS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N_PIX - 1);
    typedef enum logic [1:0] {S_LABEL, S_PIX, S_WAIT, S_DROP} state_t;
endpackage

// File: rtl/mnist_pix_counter.sv
// mnist_pix_counter: mod-N_PIX pixel counter with enable, sync clear and last-pixel flag.
module mnist_pix_counter
    import mnist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);
    assign o_last = o_cnt == CNT_LAST;

    always_ff @(posedge clk) begin
        if (rst || i_clr) o_cnt <= '0;
        else if (i_en)    o_cnt <= o_last ? '0 : o_cnt + 1'b1;
    end
endmodule

// File: rtl/mnist_sample_packer.sv
// mnist_sample_packer: packs a label byte plus 784 binarized pixels into one 794-bit word.
// Optional MNIST_SAMPLE_PACKER_STATS_EN adds saturating frames_out / frames_dropped counters.
module mnist_sample_packer
    import mnist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic [IMG_W-1:0] image_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             busy
`ifdef MNIST_SAMPLE_PACKER_STATS_EN
    ,
    output logic [15:0]      frames_out,
    output logic [15:0]      frames_dropped
`endif
);
    state_t           r_state, w_next;
    logic [IMG_W-1:0] r_asm, w_asm_nxt;
    logic [CNT_W-1:0] w_cnt, w_pix_idx, w_lbl_idx;
    logic             w_last, w_acc, w_slot, w_bad, w_load, w_label_acc;

    assign s_ready     = r_state != S_WAIT;
    assign busy        = r_state != S_LABEL;
    assign w_acc       = s_valid && s_ready;
    assign w_slot      = !out_valid || out_ready;
    assign w_bad       = s_data > LABEL_MAX;
    assign w_label_acc = r_state == S_LABEL && w_acc;
    assign w_load      = (r_state == S_PIX && w_acc && w_last && w_slot) || (r_state == S_WAIT && w_slot);
    assign w_pix_idx   = CNT_W'(PIX_LSB) + w_cnt;
    assign w_lbl_idx   = CNT_W'(LABEL_LSB) + CNT_W'(s_data[3:0]);

    mnist_pix_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_label_acc),
        .i_en   (w_acc && (r_state == S_PIX || r_state == S_DROP)),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    // The final pixel is merged here so a free slot can load the word without an extra cycle.
    always_comb begin
        w_asm_nxt = r_asm;
        if (w_label_acc && !w_bad) begin
            w_asm_nxt            = '0;
            w_asm_nxt[w_lbl_idx] = 1'b1;
        end
        if (r_state == S_PIX && w_acc) w_asm_nxt[w_pix_idx] = s_data >= PIX_THRESH;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LABEL: if (w_acc) w_next = w_bad ? S_DROP : S_PIX;
            S_PIX:   if (w_acc && w_last) w_next = w_slot ? S_LABEL : S_WAIT;
            S_WAIT:  if (w_slot) w_next = S_LABEL;
            S_DROP:  if (w_acc && w_last) w_next = S_LABEL;
            default: w_next = S_LABEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LABEL;
            r_asm      <= '0;
            image_data <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_asm     <= w_asm_nxt;
            frame_err <= w_label_acc && w_bad;
            out_valid <= w_load || (out_valid && !out_ready);
            if (w_load) image_data <= w_asm_nxt;
        end
    end

`ifdef MNIST_SAMPLE_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_out     <= '0;
            frames_dropped <= '0;
        end else begin
            if (w_load && frames_out != 16'hFFFF) frames_out <= frames_out + 16'd1;
            if (w_label_acc && w_bad && frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mnist_sample_packer.sv
// tb_mnist_sample_packer: randomized frames checked against a word-level reference model.
module tb_mnist_sample_packer;
    import mnist_pkg::*;

    logic             clk = 0, rst, s_valid, s_ready, out_valid, out_ready, frame_err, busy;
    logic [7:0]       s_data;
    logic [IMG_W-1:0] image_data;
`ifdef MNIST_SAMPLE_PACKER_STATS_EN
    logic [15:0]      frames_out, frames_dropped;
`endif

    mnist_sample_packer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .image_data (image_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef MNIST_SAMPLE_PACKER_STATS_EN
        ,
        .frames_out     (frames_out),
        .frames_dropped (frames_dropped)
`endif
    );

    always #5 clk = ~clk;

    int               n_cmp = 0, n_bad = 0, n_err = 0, bad_total = 0, good_stat = 0, bad_stat = 0, stalls = 0;
    bit               gaps = 0, rand_rdy = 0, hold = 0;
    bit [7:0]         pix [N_PIX];
    logic [IMG_W-1:0] exp_q [$];
    logic [IMG_W-1:0] last_exp, held, word_a;

    task automatic check(input string tag, input logic [IMG_W-1:0] got, input logic [IMG_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IMG_W-1:0] ref_word(input int lbl);
        logic [IMG_W-1:0] w = '0;
        w[lbl] = 1'b1;
        for (int m = 0; m < N_PIX; m++) w[N_CLASS + m] = (int'(pix[m]) >= 128);
        return w;
    endfunction

    task automatic send(input logic [7:0] b);
        bit ok = 0;
        int t = 0;
        if (gaps && $urandom_range(0, 7) == 0) begin
            s_valid = 0;
            @(posedge clk); #1;
        end
        s_valid = 1;
        s_data  = b;
        while (!ok && t < 500) begin
            @(negedge clk);
            ok = s_ready;
            if (!ok) stalls++;
            @(posedge clk); #1;
            t++;
        end
        if (!ok) check("send_timeout", 0, 1);
        s_valid = 0;
    endtask

    task automatic send_frame(input int lbl, input int mode, input int n);
        for (int m = 0; m < N_PIX; m++)
            pix[m] = mode == 1 ? (m % 2 == 0 ? 8'hFF : 8'h00) :
                     mode == 2 ? (m == 0 ? 8'h80 : m == 1 ? 8'h7F : 8'h00) :
                     ($urandom_range(0, 3) == 0 ? 8'(127 + $urandom_range(0, 1)) : 8'($urandom));
        send(8'(lbl));
        check("err_pulse", frame_err, lbl > 9);
        if (lbl > 9) begin
            bad_total++;
            bad_stat++;
        end
        for (int m = 0; m < n; m++) send(pix[m]);
        if (n == N_PIX && lbl <= 9) begin
            last_exp = ref_word(lbl);
            exp_q.push_back(last_exp);
            good_stat++;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Output monitor: every handshaken word must be the next expected one; held words must not move.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold) check("hold_stable", image_data, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_word", out_valid, 0);
                else check("word", image_data, exp_q.pop_front());
            end
            if (frame_err) n_err++;
        end
        hold = out_valid && !out_ready && !rst;
        held = image_data;
    end

    always @(posedge clk) if (rand_rdy) begin
        #1 out_ready = $urandom_range(0, 2) != 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; s_valid = 0; s_data = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        check("rst_data", image_data, 0);
        rst = 0;
        @(posedge clk); #1;
        check("rst_ready", s_ready, 1);

        send_frame(2, 1, N_PIX);
        check("t1_valid", out_valid, 1);
        check("t1_label", image_data[9:0], 10'b0000000100);
        check("t1_word", image_data, last_exp);
        drain();

        send_frame(0, 2, N_PIX);
        check("t2_pix0", image_data[10], 1);
        check("t2_pix1", image_data[11], 0);
        check("t2_lbl0", image_data[0], 1);
        drain();

        out_ready = 0;
        send_frame(3, 0, N_PIX);
        word_a = last_exp;
        send_frame(7, 0, N_PIX);
        check("t3_busy", busy, 1);
        check("t3_sready", s_ready, 0);
        check("t3_valid", out_valid, 1);
        check("t3_hold_a", image_data, word_a);
        out_ready = 1;
        @(posedge clk); #1;
        check("t3_valid_b", out_valid, 1);
        check("t3_word_b", image_data, last_exp);
        check("t3_bit7", image_data[7], 1);
        drain();

        send_frame(12, 0, N_PIX);
        check("t4_no_valid", out_valid, 0);
        send_frame(5, 0, N_PIX);
        check("t4_bit5", image_data[5], 1);
        drain();

        send_frame(4, 0, 300);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        good_stat = 0;
        bad_stat  = 0;
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_sready", s_ready, 1);
        send_frame(9, 0, N_PIX);
        check("t5_word", image_data, last_exp);
        drain();

        stalls = 0;
        for (int f = 0; f < 3; f++) send_frame($urandom_range(0, 9), 0, N_PIX);
        check("no_bubble", stalls, 0);
        drain();

        gaps = 1;
        rand_rdy = 1;
        for (int f = 0; f < 10; f++)
            send_frame($urandom_range(0, 3) == 0 ? $urandom_range(10, 255) : $urandom_range(0, 9), 0, N_PIX);
        send_frame(11, 0, N_PIX);
        @(posedge clk);
        rand_rdy = 0;
        repeat (2) @(posedge clk);
        #2 out_ready = 1;
        drain();

        check("err_count", n_err, bad_total);
`ifdef MNIST_SAMPLE_PACKER_STATS_EN
        check("frames_out", frames_out, good_stat);
        check("frames_dropped", frames_dropped, bad_stat);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
